// File: rtl/sib_fifo_sync.sv
// rtl/sib_fifo_sync.sv - single-clock FIFO controller with embedded RAM, level flags and optional FWFT output
module sib_fifo_sync #(
    parameter int WIDTH         = 64,
    parameter int DEPTH_LOG2    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int MEM_INIT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LP_DEPTH   = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LP_AFULL   = AFULL_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LP_AEMPTY  = AEMPTY_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LP_LVL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = 1;

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_rd_valid;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_avail;
    logic                  w_rd_acc;
    logic [DEPTH_LOG2:0]   w_ram_cnt;
    logic                  w_load;
    logic                  w_ram_rd;
    logic                  w_valid_nxt;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic [WIDTH-1:0]      w_ram_q;

    always_comb begin
        w_wr_acc  = wr_en && !r_full;
        w_avail   = (FWFT != 0) ? r_rd_valid : !r_empty;
        w_rd_acc  = rd_en && w_avail;
        // In FWFT mode the presented word is counted in level but no longer lives in RAM
        w_ram_cnt = r_level - {{DEPTH_LOG2{1'b0}}, r_rd_valid};
        w_load    = (w_ram_cnt != '0) && (!r_rd_valid || w_rd_acc);
        w_ram_rd    = (FWFT != 0) ? w_load : w_rd_acc;
        w_valid_nxt = (FWFT != 0) ? (w_load || (r_rd_valid && !w_rd_acc)) : w_rd_acc;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LP_LVL_ONE;
            2'b01:   w_level_nxt = r_level - LP_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    generate
        if (MEM_INIT != 0) begin : g_mem_init
            logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
            always_ff @(posedge clk) begin
                if (!rst && w_wr_acc) begin
                    r_mem[r_wr_ptr] <= wr_data;
                end
            end
            assign w_ram_q = r_mem[r_rd_ptr];
        end else begin : g_mem_plain
            logic [WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (!rst && w_wr_acc) begin
                    r_mem[r_wr_ptr] <= wr_data;
                end
            end
            assign w_ram_q = r_mem[r_rd_ptr];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_ram_rd) begin
                r_rd_ptr  <= r_rd_ptr + LP_PTR_ONE;
                r_rd_data <= w_ram_q;
            end
            r_rd_valid  <= w_valid_nxt;
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == LP_DEPTH);
            r_empty     <= (w_level_nxt == '0);
            r_afull     <= (w_level_nxt >= LP_AFULL);
            r_aempty    <= (w_level_nxt <= LP_AEMPTY);
            r_overflow  <= wr_en && r_full;
            r_underflow <= rd_en && !w_avail;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign afull     = r_afull;
    assign aempty    = r_aempty;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sib_fifo_sync.sv
// tb/tb_sib_fifo_sync.sv - self-checking bench for sib_fifo_sync in standard and FWFT modes
module tb_sib_fifo_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] wd0 = 8'h00, wd1 = 8'h00;

    logic [7:0] d0, d1;
    logic       v0, f0, e0, af0, ae0, ov0, un0;
    logic       v1, f1, e1, af1, ae1, ov1, un1;
    logic [4:0] lv0, lv1;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m0_v = 1'b0, m0_ov = 1'b0, m0_un = 1'b0;
    logic       m1_v = 1'b0, m1_ov = 1'b0, m1_un = 1'b0;
    logic [7:0] m0_d = 8'h00, m1_d = 8'h00;

    sib_fifo_sync #(.WIDTH(8), .DEPTH_LOG2(4), .FWFT(0), .MEM_INIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .wr_data(wd0), .rd_en(rd0),
        .rd_data(d0), .rd_valid(v0), .full(f0), .empty(e0), .afull(af0), .aempty(ae0),
        .level(lv0), .overflow(ov0), .underflow(un0)
    );

    sib_fifo_sync #(.WIDTH(8), .DEPTH_LOG2(4), .FWFT(1), .MEM_INIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .wr_data(wd1), .rd_en(rd1),
        .rd_data(d1), .rd_valid(v1), .full(f1), .empty(e1), .afull(af1), .aempty(ae1),
        .level(lv1), .overflow(ov1), .underflow(un1)
    );

    always #5 clk = ~clk;

    wire [19:0] act0 = {lv0, f0, e0, af0, ae0, ov0, un0, v0, d0};
    wire [19:0] act1 = {lv1, f1, e1, af1, ae1, ov1, un1, v1, d1};

    // Word-level reference: a queue holds every word the FIFO owns; flags follow from its size
    task automatic model_step();
        int   ram;
        logic wa, ra;
        if (rst) begin
            q0.delete(); q1.delete();
            m0_v = 0; m0_d = 0; m0_ov = 0; m0_un = 0;
            m1_v = 0; m1_d = 0; m1_ov = 0; m1_un = 0;
            return;
        end
        wa = wr0 && (q0.size() < 16);
        ra = rd0 && (q0.size() > 0);
        m0_ov = wr0 && !wa;
        m0_un = rd0 && !ra;
        m0_v  = ra;
        if (ra) m0_d = q0.pop_front();
        if (wa) q0.push_back(wd0);

        wa = wr1 && (q1.size() < 16);
        ra = rd1 && m1_v;
        m1_ov = wr1 && !wa;
        m1_un = rd1 && !ra;
        ram = q1.size() - (m1_v ? 1 : 0);
        if (ra) void'(q1.pop_front());
        if ((!m1_v || ra) && ram > 0) begin
            m1_v = 1'b1;
            m1_d = q1[0];
        end else if (ra) begin
            m1_v = 1'b0;
        end
        if (wa) q1.push_back(wd1);
    endtask

    function automatic logic [19:0] exp0();
        int n = q0.size();
        return {5'(n), n == 16, n == 0, n >= 14, n <= 2, m0_ov, m0_un, m0_v, m0_d};
    endfunction

    function automatic logic [19:0] exp1();
        int n = q1.size();
        return {5'(n), n == 16, n == 0, n >= 14, n <= 2, m1_ov, m1_un, m1_v, m1_d};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    endtask

    task automatic test_reset();
        rst = 1; wr0 = 1; rd0 = 1; wr1 = 1; rd1 = 1;
        cycle();
        n_run++;
        if (act0 !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL reset_std got=%h exp=%h", act0, 20'h02800);
        end
        n_run++;
        if (act1 !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL reset_fwft got=%h exp=%h", act1, 20'h02800);
        end
        rst = 0; idle();
        cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr0 = 1; wd0 = 8'(i);
            cycle();
            n_run++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL fill_model i=%0d got=%h exp=%h", i, act0, exp0());
            end
            if (i == 12 || i == 13) begin
                n_run++;
                if (af0 !== (i == 13)) begin
                    n_fail++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, af0, (i == 13));
                end
            end
        end
        n_run++;
        if (f0 !== 1'b1 || lv0 !== 5'd16) begin
            n_fail++; $display("FAIL fill_full got full=%b level=%0d exp full=1 level=16", f0, lv0);
        end
        wd0 = 8'h55;
        cycle();
        n_run++;
        if (ov0 !== 1'b1 || lv0 !== 5'd16) begin
            n_fail++; $display("FAIL fill_overflow got ov=%b level=%0d exp ov=1 level=16", ov0, lv0);
        end
        wr0 = 0;
        cycle();
        n_run++;
        if (ov0 !== 1'b0) begin
            n_fail++; $display("FAIL fill_ov_pulse got=%b exp=0", ov0);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rd0 = 1;
            cycle();
            n_run++;
            if (v0 !== 1'b1 || d0 !== 8'(i) || act0 !== exp0()) begin
                n_fail++; $display("FAIL drain i=%0d got=%h exp=%h", i, act0, exp0());
            end
        end
        n_run++;
        if (e0 !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty got=%b exp=1", e0);
        end
        cycle();
        n_run++;
        if (un0 !== 1'b1 || v0 !== 1'b0) begin
            n_fail++; $display("FAIL drain_underflow got un=%b valid=%b exp un=1 valid=0", un0, v0);
        end
        rd0 = 0;
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            wr0 = 1; wd0 = 8'($urandom);
            cycle();
        end
        rd0 = 1;
        for (int i = 0; i < 40; i++) begin
            wd0 = 8'($urandom);
            cycle();
            n_run++;
            if (act0 !== exp0() || lv0 !== 5'd8 || ov0 !== 1'b0 || un0 !== 1'b0) begin
                n_fail++; $display("FAIL b2b i=%0d got=%h exp=%h", i, act0, exp0());
            end
        end
        wr0 = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_run++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL b2b_drain i=%0d got=%h exp=%h", i, act0, exp0());
            end
        end
        rd0 = 0;
        cycle();
    endtask

    task automatic test_fwft();
        wr1 = 1; wd1 = 8'hA5;
        cycle();
        wr1 = 0;
        n_run++;
        if (v1 !== 1'b0 || lv1 !== 5'd1 || act1 !== exp1()) begin
            n_fail++; $display("FAIL fwft_lat1 got=%h exp valid=0 level=1 model=%h", act1, exp1());
        end
        cycle();
        n_run++;
        if (v1 !== 1'b1 || d1 !== 8'hA5 || act1 !== exp1()) begin
            n_fail++; $display("FAIL fwft_present got valid=%b data=%h exp valid=1 data=a5", v1, d1);
        end
        rd1 = 1;
        cycle();
        rd1 = 0;
        n_run++;
        if (e1 !== 1'b1 || v1 !== 1'b0 || act1 !== exp1()) begin
            n_fail++; $display("FAIL fwft_pop got empty=%b valid=%b exp empty=1 valid=0", e1, v1);
        end
    endtask

    task automatic test_simul_edges();
        wr0 = 1; rd0 = 1; wd0 = 8'h3C;
        cycle();
        n_run++;
        if (lv0 !== 5'd1 || un0 !== 1'b1 || ov0 !== 1'b0) begin
            n_fail++; $display("FAIL empty_wr_rd got level=%0d un=%b ov=%b exp 1 1 0", lv0, un0, ov0);
        end
        wr0 = 0;
        cycle();
        n_run++;
        if (d0 !== 8'h3C || v0 !== 1'b1) begin
            n_fail++; $display("FAIL empty_wr_rd_data got=%h exp=3c", d0);
        end
        rd0 = 0; wr0 = 1;
        for (int i = 0; i < 16; i++) begin
            wd0 = 8'($urandom);
            cycle();
        end
        rd0 = 1; wd0 = 8'hEE;
        cycle();
        n_run++;
        if (lv0 !== 5'd15 || ov0 !== 1'b1 || un0 !== 1'b0 || act0 !== exp0()) begin
            n_fail++; $display("FAIL full_wr_rd got=%h exp=%h", act0, exp0());
        end
        wr0 = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_run++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL full_wr_rd_drain i=%0d got=%h exp=%h", i, act0, exp0());
            end
        end
        rd0 = 0;
        cycle();
    endtask

    task automatic test_reset_mid();
        wr0 = 1;
        for (int i = 0; i < 9; i++) begin
            wd0 = 8'(8'h90 + i);
            cycle();
        end
        n_run++;
        if (lv0 !== 5'd9) begin
            n_fail++; $display("FAIL rstmid_pre got level=%0d exp=9", lv0);
        end
        rd0 = 1; rst = 1;
        cycle();
        rst = 0;
        n_run++;
        if (lv0 !== 5'd0 || e0 !== 1'b1 || v0 !== 1'b0 || ov0 !== 1'b0 || un0 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid got level=%0d empty=%b valid=%b ov=%b un=%b", lv0, e0, v0, ov0, un0);
        end
        rd0 = 0; wd0 = 8'h77;
        cycle();
        wr0 = 0; rd0 = 1;
        cycle();
        n_run++;
        if (v0 !== 1'b1 || d0 !== 8'h77 || act0 !== exp0()) begin
            n_fail++; $display("FAIL rstmid_newdata got valid=%b data=%h exp valid=1 data=77", v0, d0);
        end
        rd0 = 0;
        cycle();
    endtask

    task automatic test_random();
        int wp, rp;
        for (int i = 0; i < 800; i++) begin
            case (i / 200)
                0:       begin wp = 70; rp = 30; end
                1:       begin wp = 30; rp = 70; end
                2:       begin wp = 90; rp = 50; end
                default: begin wp = 50; rp = 90; end
            endcase
            wr0 = ($urandom_range(0, 99) < wp); wd0 = 8'($urandom);
            rd0 = ($urandom_range(0, 99) < rp);
            wr1 = ($urandom_range(0, 99) < wp); wd1 = 8'($urandom);
            rd1 = ($urandom_range(0, 99) < rp);
            cycle();
            n_run++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL rand_std i=%0d got=%h exp=%h", i, act0, exp0());
            end
            n_run++;
            if (act1 !== exp1()) begin
                n_fail++; $display("FAIL rand_fwft i=%0d got=%h exp=%h", i, act1, exp1());
            end
        end
        idle();
        cycle();
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_simul_edges();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
